// File: rtl/tiny_bnn_driver.sv
// tiny_bnn_driver: host-side driver for the tiny_bnn 8-pin io_in interface.
// Generates the DUT clock, shifts parameters bit-serially, runs nibble inference.
module tiny_bnn_driver #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_data,
    input  logic       cfg_last,
    input  logic       x_valid,
    output logic       x_ready,
    input  logic [7:0] x_data,
    output logic       y_valid,
    output logic [7:0] y_data,
    output logic       busy,
    output logic [7:0] io_in_drv,
    input  logic [7:0] io_out_dut
);

    typedef enum logic [3:0] {
        IDLE,
        LD_LO,
        LD_HI,
        XL_LO,
        XL_HI,
        XH_LO,
        XH_HI,
        SETTLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [7:0] sh_q;
    logic [2:0] bit_q;
    logic       last_q;
    logic       load_open_q;
    logic [7:0] x_q;
    logic [3:0] settle_q;
    logic [3:0] nib_q;
    logic       bank_q;
    logic       param_q;
    logic       setup_q;
    logic       dclk_q;
    logic       cfg_ready_q;
    logic       x_ready_q;
    logic       y_valid_q;
    logic [7:0] y_data_q;

    // Accept decisions in IDLE; cfg wins when both streams are offered.
    logic cfg_acc_d;
    logic x_acc_d;

    // Accept decode for the two host streams.
    always_comb begin
        cfg_acc_d = 1'b0;
        x_acc_d   = 1'b0;
        if (state_q == IDLE) begin
            cfg_acc_d = cfg_valid && cfg_ready_q;
            x_acc_d   = !cfg_acc_d && x_valid && x_ready_q;
        end
    end

    // Main sequencer: every DUT clock is a LO (data update) / HI (edge) pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= 8'h00;
            bit_q       <= 3'd0;
            last_q      <= 1'b0;
            load_open_q <= 1'b0;
            x_q         <= 8'h00;
            settle_q    <= 4'd0;
            nib_q       <= 4'h0;
            bank_q      <= 1'b0;
            param_q     <= 1'b0;
            setup_q     <= 1'b0;
            dclk_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            x_ready_q   <= 1'b0;
            y_valid_q   <= 1'b0;
            y_data_q    <= 8'h00;
        end else begin
            y_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    dclk_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                    x_ready_q   <= !load_open_q;
                    if (cfg_acc_d) begin
                        sh_q        <= cfg_data;
                        last_q      <= cfg_last;
                        load_open_q <= 1'b1;
                        param_q     <= cfg_data[0];
                        setup_q     <= 1'b1;
                        bit_q       <= 3'd0;
                        cfg_ready_q <= 1'b0;
                        x_ready_q   <= 1'b0;
                        state_q     <= LD_LO;
                    end else if (x_acc_d) begin
                        x_q         <= x_data;
                        nib_q       <= x_data[3:0];
                        bank_q      <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        x_ready_q   <= 1'b0;
                        state_q     <= XL_LO;
                    end
                end
                LD_LO: begin
                    dclk_q  <= 1'b1;
                    state_q <= LD_HI;
                end
                LD_HI: begin
                    dclk_q <= 1'b0;
                    if (bit_q == 3'd7) begin
                        cfg_ready_q <= 1'b1;
                        state_q     <= IDLE;
                        if (last_q) begin
                            load_open_q <= 1'b0;
                            setup_q     <= 1'b0;
                            x_ready_q   <= 1'b1;
                        end else begin
                            x_ready_q <= 1'b0;
                        end
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        sh_q    <= {1'b0, sh_q[7:1]};
                        param_q <= sh_q[1];
                        state_q <= LD_LO;
                    end
                end
                XL_LO: begin
                    dclk_q  <= 1'b1;
                    state_q <= XL_HI;
                end
                XL_HI: begin
                    dclk_q  <= 1'b0;
                    nib_q   <= x_q[7:4];
                    bank_q  <= 1'b1;
                    state_q <= XH_LO;
                end
                XH_LO: begin
                    dclk_q  <= 1'b1;
                    state_q <= XH_HI;
                end
                XH_HI: begin
                    dclk_q   <= 1'b0;
                    settle_q <= SETTLE_M1;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == 4'd0) begin
                        y_data_q  <= io_out_dut;
                        y_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                DONE: begin
                    cfg_ready_q <= 1'b1;
                    x_ready_q   <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign x_ready   = x_ready_q;
    assign y_valid   = y_valid_q;
    assign y_data    = y_data_q;
    assign busy      = (state_q != IDLE);
    assign io_in_drv = {nib_q, bank_q, param_q, setup_q, dclk_q};

endmodule

// File: tb/tb_tiny_bnn_driver.sv
// tb_tiny_bnn_driver: randomized bench with a behavioural tiny_bnn model
// (parameter shift chain plus an inverting two-bank input register).
module tb_tiny_bnn_driver;

    localparam int S = 2;
    localparam int NREC = 2048;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_last = 1'b0;
    logic       x_valid = 1'b0;
    logic       x_ready;
    logic [7:0] x_data = 8'h00;
    logic       y_valid;
    logic [7:0] y_data;
    logic       busy;
    logic [7:0] io_in_drv;
    logic [7:0] io_out_dut;

    tiny_bnn_driver #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .y_valid   (y_valid),
        .y_data    (y_data),
        .busy      (busy),
        .io_in_drv (io_in_drv),
        .io_out_dut(io_out_dut)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    // Behavioural tiny_bnn: 16-bit parameter chain, two nibble banks, y = ~x.
    logic [15:0] chain = 16'h0000;
    logic [3:0]  m_lo = 4'h0;
    logic [3:0]  m_hi = 4'h0;
    logic [7:0]  prev = 8'h00;
    assign io_out_dut = ~{m_hi, m_lo};

    logic [7:0] drv_a [NREC];
    logic       crdy_a[NREC];
    logic       xrdy_a[NREC];
    logic       yv_a  [NREC];
    logic [7:0] yd_a  [NREC];
    logic       busy_a[NREC];
    logic [7:0] yq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle recorder, DUT pin model and edge-integrity watcher.
    always @(negedge clk) begin
        if (cyc < NREC) begin
            drv_a[cyc]  <= io_in_drv;
            crdy_a[cyc] <= cfg_ready;
            xrdy_a[cyc] <= x_ready;
            yv_a[cyc]   <= y_valid;
            yd_a[cyc]   <= y_data;
            busy_a[cyc] <= busy;
        end
        if (y_valid === 1'b1) yq.push_back(y_data);
        if (io_in_drv[0] === 1'b1 && prev[0] === 1'b0) begin
            n_tests++;
            if (io_in_drv[7:1] !== prev[7:1]) begin
                n_fail++;
                $display("FAIL edge_data cyc=%0d got %h prev %h", cyc, io_in_drv, prev);
            end
            if (io_in_drv[1]) chain <= {io_in_drv[2], chain[15:1]};
            else if (io_in_drv[3]) m_hi <= io_in_drv[7:4];
            else m_lo <= io_in_drv[7:4];
        end
        if (io_in_drv[0] === 1'b1 && io_in_drv[1] !== prev[1]) begin
            n_tests++;
            n_fail++;
            $display("FAIL setup_while_high cyc=%0d got %b prev %b", cyc, io_in_drv[1], prev[1]);
        end
        prev <= io_in_drv;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send_cfg(input logic [7:0] d, input logic l, output int t);
        cfg_data = d;
        cfg_last = l;
        cfg_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                t = cyc;
                break;
            end
        end
        tick();
        cfg_valid = 1'b0;
        n_tests++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL cfg_accept got timeout required accept");
        end
    endtask

    task automatic send_x(input logic [7:0] d, output int t);
        x_data = d;
        x_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (x_ready) begin
                t = cyc;
                break;
            end
        end
        tick();
        x_valid = 1'b0;
        n_tests++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL x_accept got timeout required accept");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if (io_in_drv !== 8'h00 || cfg_ready !== 1'b0 || x_ready !== 1'b0 ||
            busy !== 1'b0 || y_valid !== 1'b0 || y_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_vals got drv=%h cr=%b xr=%b b=%b yv=%b yd=%h required 00 0 0 0 0 00",
                     io_in_drv, cfg_ready, x_ready, busy, y_valid, y_data);
        end
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (io_in_drv !== 8'h00 || y_valid !== 1'b0 || cfg_ready !== 1'b1 ||
                x_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset got drv=%h yv=%b cr=%b xr=%b required 00 0 1 1",
                         io_in_drv, y_valid, cfg_ready, x_ready);
            end
        end
        tick();
    endtask

    task automatic test_single_byte();
        int t;
        logic [7:0] b;
        logic [7:0] lo;
        logic [7:0] hi;
        b = 8'hA5;
        send_cfg(b, 1'b1, t);
        wait_cyc(t + 19);
        for (int k = 0; k < 8; k++) begin
            lo = drv_a[t + 1 + 2 * k];
            hi = drv_a[t + 2 + 2 * k];
            n_tests++;
            if (lo[0] !== 1'b0 || hi[0] !== 1'b1 || lo[1] !== 1'b1 ||
                hi[1] !== 1'b1 || hi[2] !== b[k]) begin
                n_fail++;
                $display("FAIL load_bit%0d got lo=%h hi=%h required param %b setup 1", k, lo, hi, b[k]);
            end
        end
        n_tests++;
        if (drv_a[t + 17][1:0] !== 2'b00 || crdy_a[t + 17] !== 1'b1 || crdy_a[t + 1] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_end got setup/clk=%b cr17=%b cr1=%b required 00 1 0",
                     drv_a[t + 17][1:0], crdy_a[t + 17], crdy_a[t + 1]);
        end
        n_tests++;
        if (chain[15:8] !== b) begin
            n_fail++;
            $display("FAIL chain_single got %h required %h", chain[15:8], b);
        end
    endtask

    task automatic test_two_byte();
        int t1;
        int t2;
        int tx;
        logic [7:0] xv;
        logic bad;
        xv = 8'($urandom);
        x_data = xv;
        x_valid = 1'b1;
        send_cfg(8'h0F, 1'b0, t1);
        send_cfg(8'hF0, 1'b1, t2);
        n_tests++;
        if (t2 !== t1 + 17) begin
            n_fail++;
            $display("FAIL b2b_cfg got t2-t1=%0d required 17", t2 - t1);
        end
        n_tests++;
        if (drv_a[t1 + 17][1:0] !== 2'b10) begin
            n_fail++;
            $display("FAIL interbyte got setup/clk=%b required 10", drv_a[t1 + 17][1:0]);
        end
        tx = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (x_ready) begin
                tx = cyc;
                break;
            end
        end
        tick();
        x_valid = 1'b0;
        bad = 1'b0;
        for (int c = t1 + 1; c <= t2 + 16; c++) if (xrdy_a[c] !== 1'b0) bad = 1'b1;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL xready_in_load got 1 required 0");
        end
        n_tests++;
        if (tx !== t2 + 17) begin
            n_fail++;
            $display("FAIL x_after_load got %0d required %0d", tx, t2 + 17);
        end
        n_tests++;
        if (chain !== 16'hF00F) begin
            n_fail++;
            $display("FAIL chain_two got %h required F00F", chain);
        end
        wait_cyc(tx + S + 8);
        n_tests++;
        if (yv_a[tx + 5 + S] !== 1'b1 || yd_a[tx + 5 + S] !== ~xv) begin
            n_fail++;
            $display("FAIL y_after_load got yv=%b yd=%h required 1 %h",
                     yv_a[tx + 5 + S], yd_a[tx + 5 + S], ~xv);
        end
    endtask

    task automatic test_infer();
        int t;
        logic [7:0] v;
        logic [7:0] e2;
        logic [7:0] e4;
        for (int n = 0; n < 5; n++) begin
            v = (n == 0) ? 8'h3C : 8'($urandom);
            send_x(v, t);
            wait_cyc(t + S + 8);
            e2 = drv_a[t + 2];
            e4 = drv_a[t + 4];
            n_tests++;
            if (drv_a[t + 1][0] !== 1'b0 || e2[0] !== 1'b1 || e2[7:4] !== v[3:0] || e2[3] !== 1'b0 ||
                drv_a[t + 3][0] !== 1'b0 || e4[0] !== 1'b1 || e4[7:4] !== v[7:4] || e4[3] !== 1'b1) begin
                n_fail++;
                $display("FAIL infer_nibbles x=%h got e2=%h e4=%h", v, e2, e4);
            end
            n_tests++;
            if (yv_a[t + 4 + S] !== 1'b0 || yv_a[t + 5 + S] !== 1'b1 ||
                yv_a[t + 6 + S] !== 1'b0 || yd_a[t + 5 + S] !== ~v) begin
                n_fail++;
                $display("FAIL infer_y x=%h got yv=%b%b%b yd=%h required 010 %h", v,
                         yv_a[t + 4 + S], yv_a[t + 5 + S], yv_a[t + 6 + S], yd_a[t + 5 + S], ~v);
            end
            n_tests++;
            if (busy_a[t + 5 + S] !== 1'b1 || busy_a[t + 6 + S] !== 1'b0 ||
                xrdy_a[t + 6 + S] !== 1'b1 || drv_a[t + 5][0] !== 1'b0) begin
                n_fail++;
                $display("FAIL infer_tail got busy=%b%b xr=%b required 10 1",
                         busy_a[t + 5 + S], busy_a[t + 6 + S], xrdy_a[t + 6 + S]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int t;
        int tx;
        logic [7:0] b;
        logic [7:0] xv;
        b = 8'($urandom);
        xv = 8'($urandom);
        cfg_data = b;
        cfg_last = 1'b1;
        x_data = xv;
        cfg_valid = 1'b1;
        x_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                t = cyc;
                break;
            end
        end
        tick();
        cfg_valid = 1'b0;
        tx = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (x_ready) begin
                tx = cyc;
                break;
            end
        end
        tick();
        x_valid = 1'b0;
        n_tests++;
        if (drv_a[t + 1][1] !== 1'b1 || tx !== t + 17) begin
            n_fail++;
            $display("FAIL cfg_priority got setup=%b tx-t=%0d required 1 17", drv_a[t + 1][1], tx - t);
        end
        wait_cyc(tx + S + 8);
        n_tests++;
        if (chain[15:8] !== b || yd_a[tx + 5 + S] !== ~xv) begin
            n_fail++;
            $display("FAIL sim_results got chain=%h y=%h required %h %h",
                     chain[15:8], yd_a[tx + 5 + S], b, ~xv);
        end
    endtask

    task automatic test_back_to_back();
        int t[4];
        logic [7:0] v[4];
        yq.delete();
        x_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v[i] = 8'($urandom);
            x_data = v[i];
            t[i] = -1;
            for (int j = 0; j < 100; j++) begin
                @(negedge clk);
                if (x_ready) begin
                    t[i] = cyc;
                    break;
                end
            end
            tick();
        end
        x_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (t[i] - t[i - 1] !== 6 + S) begin
                n_fail++;
                $display("FAIL b2b_period%0d got %0d required %0d", i, t[i] - t[i - 1], 6 + S);
            end
        end
        wait_cyc(t[3] + S + 8);
        n_tests++;
        if (yq.size() !== 4) begin
            n_fail++;
            $display("FAIL b2b_count got %0d required 4", yq.size());
        end
        for (int i = 0; i < 4 && i < yq.size(); i++) begin
            n_tests++;
            if (yq[i] !== ~v[i]) begin
                n_fail++;
                $display("FAIL b2b_y%0d got %h required %h", i, yq[i], ~v[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int t;
        send_cfg(8'($urandom), 1'b0, t);
        wait_cyc(t + 9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (io_in_drv !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_load got drv=%h busy=%b required 00 0", io_in_drv, busy);
        end
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (x_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_load_open got xr=%b required 1", x_ready);
        end
        tick();
        yq.delete();
        send_x(8'($urandom), t);
        wait_cyc(t + 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (io_in_drv !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_settle got drv=%h busy=%b required 00 0", io_in_drv, busy);
        end
        repeat (10) tick();
        n_tests++;
        if (yq.size() !== 0) begin
            n_fail++;
            $display("FAIL abort_no_y got %0d pulses required 0", yq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_two_byte();
        test_infer();
        test_simultaneous();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tiny_bnn_driver.md
# tiny_bnn_driver

Host-side driver for the `tiny_bnn` 8-pin input interface: it produces the `io_in` byte the network consumes and captures its `io_out` result. Bit-serial parameter loading and nibble-multiplexed inference, both timed by a DUT clock the driver generates itself, are exposed as simple valid/ready streams. The block sits between an on-chip controller or test harness and the `tiny_bnn` instance.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: `clk` cycles to wait after the last DUT clock edge before sampling `io_out`. Legal range is 1..15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  parameter byte offered.
- `cfg_ready`  out  1  driver accepts a parameter byte.
- `cfg_data`  in  8  parameter byte, shifted out LSB first.
- `cfg_last`  in  1  marks the final byte of a parameter load.
- `x_valid`  in  1  inference request offered.
- `x_ready`  out  1  driver accepts an inference request.
- `x_data`  in  8  input vector for the network.
- `y_valid`  out  1  one-cycle pulse; `y_data` is valid.
- `y_data`  out  8  captured `io_out`.
- `busy`  out  1  high whenever the state is not IDLE.
- `io_in_drv`  out  8  carries `{nibble[3:0], x_bank_hi, param_in, setup, dut_clk}` to the DUT `io_in`.
- `io_out_dut`  in  8  DUT `io_out`.

## Operation
- DUT protocol:
  - While `setup`=1, each rising `dut_clk` shifts `param_in` into the DUT parameter chain.
  - While `setup`=0, each rising `dut_clk` latches the nibble into the bank selected by `x_bank_hi` (0 = bits 3:0, 1 = bits 7:4).
- FSM states: IDLE, LD_LO, LD_HI, XL_LO, XL_HI, XH_LO, XH_HI, SETTLE, DONE.
- Phase convention for every DUT clock:
  - *_LO states drive `dut_clk`=0 and update data.
  - *_HI states drive `dut_clk`=1 and hold data.
- IDLE:
  - `cfg_ready`=1.
  - `x_ready`=1 only when `load_open`=0.
  - If both streams are valid, cfg wins.
- Parameter load:
  - The accepted byte goes into an 8-bit shift register, with a 3-bit bit counter.
  - Sequence is LD_LO → LD_HI, repeated 8 times, then back to IDLE.
  - `load_open` sets on accept. It clears at the end of a byte whose `cfg_last` was 1.
  - `setup`=1 from the first LD_LO until `load_open` clears. Between bytes of an open load, `setup` stays 1 and `dut_clk` stays 0.
- Inference:
  - Sequence is XL_LO/XL_HI (`x_bank_hi`=0, `x_data[3:0]`), then XH_LO/XH_HI (`x_bank_hi`=1, `x_data[7:4]`).
  - Then SETTLE with `dut_clk`=0 for `SETTLE_CYCLES`; `io_out_dut` is registered on the last SETTLE cycle.
  - Then DONE: `y_valid`=1, then IDLE.
- In IDLE outside a load, `io_in_drv` holds its last data bits with `dut_clk`=0 and `setup`=0.
- `y_data` holds its value until the next capture.

## Timing
- Reset values:
  - `io_in_drv`=8'h00.
  - `cfg_ready`=0, `x_ready`=0, `y_valid`=0, `y_data`=8'h00, `busy`=0, `load_open`=0.
  - State is IDLE; the ready signals go high in the first cycle after reset deasserts.
- Parameter byte accepted in cycle T:
  - Bit k is driven in cycle T+1+2k with `dut_clk`=0.
  - The rising edge for bit k is in cycle T+2+2k, so bit 7 rises at T+16.
  - The FSM is in IDLE at T+17, with `cfg_ready`=1 in that cycle.
  - If `cfg_last` was set, `setup` drops at T+17.
- Inference accepted in cycle T:
  - Low nibble driven at T+1, rising edge at T+2.
  - High nibble driven at T+3, rising edge at T+4.
  - SETTLE covers T+5 .. T+4+`SETTLE_CYCLES`.
  - `y_valid` pulses at T+5+`SETTLE_CYCLES` (T+7 at default).
  - IDLE and `x_ready`=1 follow one cycle later.
- Throughput:
  - Parameter load takes 17 cycles per byte.
  - Inference takes 6+`SETTLE_CYCLES` cycles per request.
- Edge-integrity rules:
  - `dut_clk` never goes high in the same cycle that `param_in`, `setup`, the nibble or `x_bank_hi` changes.
  - `setup` changes only while `dut_clk`=0.
- `x_valid` during an open load is not accepted (`x_ready`=0) until the byte with `cfg_last` completes.
- Reset mid-operation aborts immediately:
  - Next cycle `dut_clk`=0 and `setup`=0, and no `y_valid` is issued.
  - Any partial parameter chain in the DUT is undefined; the host must reload.
- Back-to-back requests: a request held valid at the IDLE cycle is accepted there, with no bubble beyond the IDLE cycle.

## Test plan
- Reset, then idle with no stimulus → `io_in_drv`=8'h00 and `y_valid`=0 throughout; `cfg_ready`=`x_ready`=1 from the first post-reset cycle.
- Single byte 8'hA5 with `cfg_last` accepted at T → `param_in` over rising edges T+2..T+16 reads 1,0,1,0,0,1,0,1; `setup`=1 at T+1..T+16, 0 at T+17; `cfg_ready` back to 1 at T+17.
- Two-byte load 8'h0F then 8'hF0 (last), with `x_valid` held high throughout → `x_ready`=0 until the second byte completes; `setup` stays 1 in the inter-byte IDLE; a model shift chain holds 16'hF00F.
- Inference of 8'h3C with a DUT model returning `~x` and `SETTLE_CYCLES`=2, accepted at T → nibble/bank pairs 4'hC/0 at edge T+2 and 4'h3/1 at edge T+4; `y_valid` at T+7 with `y_data`=8'hC3.
- Simultaneous `cfg_valid` and `x_valid` in IDLE → cfg is accepted first; x is accepted only after the cfg byte (with `cfg_last`) completes.
- `reset` asserted during the 5th bit of a load and during SETTLE → next cycle `io_in_drv`=8'h00 and `busy`=0, with no `y_valid` pulse.
